// File: rtl/mul_recon.sv
// Multiplicative reconstruction n = q*d + r using a 9-iteration LSB-first shift-add FSM.
// Optional remainder check (r >= d) enabled by defining MUL_RECON_REMCHK_EN.
module mul_recon (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  q_in,
  input  logic [8:0]  d_in,
  input  logic [8:0]  r_in,
  output logic [17:0] n_out,
  output logic        valid,
  output logic        busy,
  output logic        rem_err
);

  localparam int DATA_W = 9;
  localparam int ACC_W  = 2 * DATA_W;
  localparam logic [3:0] LAST_ITER = 4'd8;

  typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_q;
  logic [DATA_W-1:0]   r_d;
  logic [DATA_W-1:0]   r_r;
  logic [3:0]          r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_n;
  logic                r_valid;
  logic                r_busy;
  logic [ACC_W-1:0]    w_addend;
  logic [ACC_W-1:0]    w_result;

  // Partial product for the current iteration: d aligned to the weight of q bit r_cnt.
  assign w_addend = r_q[r_cnt] ? ({{DATA_W{1'b0}}, r_d} << r_cnt) : '0;
  assign w_result = r_acc + {{DATA_W{1'b0}}, r_r};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_d     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_n     <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_q     <= q_in;
            r_d     <= d_in;
            r_r     <= r_in;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_acc <= r_acc + w_addend;
          if (r_cnt == LAST_ITER) begin
            r_state <= FIN;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        FIN: begin
          r_n     <= w_result;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign n_out = r_n;
  assign valid = r_valid;
  assign busy  = r_busy;

`ifdef MUL_RECON_REMCHK_EN
  logic r_rem_err;

  // Flag is refreshed only on FIN so it stays aligned with the held n_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem_err <= 1'b0;
    end else if (r_state == FIN) begin
      r_rem_err <= (r_r >= r_d);
    end
  end

  assign rem_err = r_rem_err;
`else
  assign rem_err = 1'b0;
`endif

endmodule

// File: doc/mul_recon.md
MUL_RECON -- requirements
Module: mul_recon

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request to begin one reconstruction, sampled in IDLE only.
REQ-004 SHALL have port: q_in  input  9  unsigned quotient.
REQ-005 SHALL have port: d_in  input  9  unsigned denominator.
REQ-006 SHALL have port: r_in  input  9  unsigned remainder.
REQ-007 SHALL have port: n_out  output  18  reconstructed numerator, n = q*d + r, held until the next result.
REQ-008 SHALL have port: valid  output  1  one-cycle pulse marking a new n_out.
REQ-009 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port: rem_err  output  1  remainder-check flag, qualified by valid (see Configuration).

Function
REQ-011 SHALL implement FSM states IDLE, ADD, FIN, with IDLE as the reset state.
REQ-012 IDLE: start=1 at a rising edge SHALL capture q_in, d_in, r_in into internal registers, clear the accumulator and iteration counter, and move to ADD; start=0 SHALL stay in IDLE.
REQ-013 ADD SHALL run exactly 9 iterations, LSB-first shift-add: if the current q bit is 1, add d shifted by the iteration index to the 18-bit accumulator; the 4-bit counter counts 0..8.
REQ-014 ADD SHALL move to FIN after the iteration with counter=8.
REQ-015 FIN SHALL write accumulator + captured r to n_out, pulse valid high for exactly one cycle, and return to IDLE.
REQ-016 Latency: valid and the new n_out SHALL appear after the 11th rising edge, counting the start-sampling edge as the 1st.
REQ-017 Throughput: one result per 11 cycles; start SHALL be accepted in the cycle valid is high (back-to-back operation).
REQ-018 start asserted while busy=1 SHALL be ignored, not queued.
REQ-019 Input changes while busy=1 SHALL NOT affect the running result.
REQ-020 Arithmetic SHALL be unsigned with an 18-bit result; the maximum 511*511+511=261632 fits, so no overflow or saturation logic is required.
REQ-021 q_in=0 or d_in=0 SHALL still take the full 11-cycle latency and return n_out=r_in.

Reset
REQ-022 reset=1 SHALL immediately force state=IDLE, counter=0, accumulator=0, n_out=0, valid=0, busy=0, rem_err=0, regardless of clk.
REQ-023 Reset mid-operation SHALL abort the computation with no valid pulse; the first start after reset release SHALL begin a fresh computation.

Configuration
REQ-024 Macro MUL_RECON_REMCHK_EN defined: in FIN, rem_err SHALL be set to 1 when captured r >= captured d (including d=0), otherwise 0, and SHALL hold until the next FIN or reset; n_out is computed regardless.
REQ-025 Macro MUL_RECON_REMCHK_EN undefined: the rem_err port SHALL remain and be tied to constant 0, with no compare logic.

Verification
REQ-026 q=13, d=7, r=5, start pulsed -> n_out=96 and a single-cycle valid at the 11th edge; busy high edges 1..10.
REQ-027 q=511, d=511, r=511 -> n_out=261632.
REQ-028 q=0, d=200, r=17 -> n_out=17 after the full 11-cycle latency.
REQ-029 start re-pulsed at edge 5 with q=1, d=1, r=0 -> ignored, result stays 96 for the first operands; start held high continuously -> results every 11 cycles.
REQ-030 reset asserted at edge 6, then released, then q=3, d=4, r=1 started -> no valid before the new run, then n_out=13.
REQ-031 With MUL_RECON_REMCHK_EN: q=2, d=9, r=9 -> n_out=27, rem_err=1; q=2, d=9, r=8 -> rem_err=0. Without the macro: rem_err=0 always.
